smg_encode_module: RTL and testbench

Upstream stage of the two-digit seven-segment display path. It converts a 7-bit binary value (0–99) into tens and ones digits using a sequential shift-add-3 (double-dabble) converter. It then encodes each digit as an 8-bit active-low segment pattern and holds both patterns on `Ten_SMG_Data` and `One_SMG_Data` for the row-scan stage to consume. A conversion runs on a start pulse and reports completion with a one-cycle done pulse.

---
 rtl/smg_encode_module.sv | 90 +++++++++
 tb/tb_smg_encode_module.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/smg_encode_module.sv
// smg_encode_module: binary 0..99 to two active-low seven-segment patterns via sequential double-dabble
module smg_encode_module #(
   parameter bit BLANK_LEADING_ZERO = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [6:0] Number_Data,
   input  logic       Start_Sig,
   output logic [7:0] Ten_SMG_Data,
   output logic [7:0] One_SMG_Data,
   output logic       Done_Sig
);
   typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;
   state_t      state_q;
   logic [6:0]  bin_q, bin_d;
   logic [7:0]  bcd_q, bcd_d, adj;
   logic [14:0] sh;
   logic [2:0]  cnt_q;
   logic        oor_q, done_q;
   logic [7:0]  ten_q, one_q, ten_d, one_d;

   function automatic logic [7:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 8'hC0;
         4'd1:    seg = 8'hF9;
         4'd2:    seg = 8'hA4;
         4'd3:    seg = 8'hB0;
         4'd4:    seg = 8'h99;
         4'd5:    seg = 8'h92;
         4'd6:    seg = 8'h82;
         4'd7:    seg = 8'hF8;
         4'd8:    seg = 8'h80;
         4'd9:    seg = 8'h90;
         default: seg = 8'hBF;
      endcase
   endfunction

   // one add-3/shift step of the converter, plus the patterns the final BCD value maps to
   always_comb begin
      adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
      adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
      sh       = {adj, bin_q} << 1;
      bcd_d    = sh[14:7];
      bin_d    = sh[6:0];
      one_d    = oor_q ? 8'hBF : seg(bcd_q[3:0]);
      ten_d    = oor_q ? 8'hBF : (BLANK_LEADING_ZERO && bcd_q[7:4] == 4'd0) ? 8'hFF : seg(bcd_q[7:4]);
   end

   // control FSM: capture on start, seven shift iterations, then register patterns and pulse done
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         oor_q   <= 1'b0;
         done_q  <= 1'b0;
         ten_q   <= 8'hFF;
         one_q   <= 8'hFF;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (Start_Sig) begin
               bin_q   <= Number_Data;
               bcd_q   <= '0;
               cnt_q   <= '0;
               oor_q   <= Number_Data > 7'd99;
               state_q <= SHIFT;
            end
            SHIFT: begin
               bcd_q   <= bcd_d;
               bin_q   <= bin_d;
               cnt_q   <= cnt_q + 3'd1;
               state_q <= (cnt_q == 3'd6) ? ENCODE : SHIFT;
            end
            ENCODE: begin
               ten_q   <= ten_d;
               one_q   <= one_d;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Ten_SMG_Data = ten_q;
   assign One_SMG_Data = one_q;
   assign Done_Sig     = done_q;
endmodule

// File: tb/tb_smg_encode_module.sv
// tb_smg_encode_module: directed checks of conversion, blanking, bounds, busy starts and reset
module tb_smg_encode_module;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] num = '0;
   logic       start = 1'b0;
   logic [7:0] ten, one, ten0, one0;
   logic       done, done0;
   int         total = 0;
   int         bad = 0;

   smg_encode_module dut (
      .CLK(clk), .RST(rst), .Number_Data(num), .Start_Sig(start),
      .Ten_SMG_Data(ten), .One_SMG_Data(one), .Done_Sig(done)
   );

   smg_encode_module #(.BLANK_LEADING_ZERO(1'b0)) dut0 (
      .CLK(clk), .RST(rst), .Number_Data(num), .Start_Sig(start),
      .Ten_SMG_Data(ten0), .One_SMG_Data(one0), .Done_Sig(done0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // called at a negedge; leaves the bench at the negedge after the accepting edge
   task automatic go(input logic [6:0] n);
      num = n;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // k further edges up to edge 7, then edge 8 must bring done and the patterns
   task automatic wait_done(input string tag, input int k, input logic [7:0] t, input logic [7:0] o);
      repeat (k) @(posedge clk);
      @(negedge clk);
      chk({tag, "_early"}, {7'd0, done}, 8'd0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_done"}, {7'd0, done}, 8'd1);
      chk({tag, "_ten"}, ten, t);
      chk({tag, "_one"}, one, o);
   endtask

   task automatic done_off(input string tag);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_fall"}, {7'd0, done}, 8'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ten", ten, 8'hFF);
      chk("rst_one", one, 8'hFF);
      chk("rst_done", {7'd0, done}, 8'd0);
      start = 1'b1;
      num = 7'd42;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("idle_ten", ten, 8'hFF);
      chk("idle_one", one, 8'hFF);
      chk("rst_prio_done", {7'd0, done}, 8'd0);

      go(7'd42);
      wait_done("v42", 7, 8'h99, 8'hA4);
      chk("v42_ten_nb", ten0, 8'h99);
      done_off("v42");
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("hold_done", {7'd0, done}, 8'd0);
         chk("hold_ten", ten, 8'h99);
         chk("hold_one", one, 8'hA4);
      end

      go(7'd7);
      wait_done("v7", 7, 8'hFF, 8'hF8);
      chk("v7_ten_nb", ten0, 8'hC0);
      chk("v7_one_nb", one0, 8'hF8);
      done_off("v7");
      go(7'd0);
      wait_done("v0", 7, 8'hFF, 8'hC0);
      chk("v0_ten_nb", ten0, 8'hC0);
      done_off("v0");

      go(7'd99);
      wait_done("v99", 7, 8'h90, 8'h90);
      done_off("v99");
      go(7'd100);
      wait_done("v100", 7, 8'hBF, 8'hBF);
      chk("v100_ten_nb", ten0, 8'hBF);
      done_off("v100");
      go(7'd127);
      wait_done("v127", 7, 8'hBF, 8'hBF);
      done_off("v127");

      go(7'd42);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      num = 7'd15;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done("busy", 4, 8'h99, 8'hA4);
      go(7'd15);
      chk("b2b_fall", {7'd0, done}, 8'd0);
      wait_done("b2b", 7, 8'hF9, 8'h92);
      done_off("b2b");

      go(7'd58);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("mid_ten", ten, 8'hFF);
      chk("mid_one", one, 8'hFF);
      chk("mid_done", {7'd0, done}, 8'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("mid_nodone", {7'd0, done}, 8'd0);
      end
      go(7'd58);
      wait_done("v58", 7, 8'h92, 8'h80);
      done_off("v58");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
